// File: rtl/register_writeback.sv
// Writeback buffer between the execution-unit result ports and the
// register-file write ports. Results are queued in arrival order: lower port
// index first within a cycle. The queue drains up to SUPER_SCALAR_WIDTH
// entries per cycle, and a drain never carries two writes to the same register.

package processor_help;
   localparam int SUPER_SCALAR_WIDTH = 2;
   localparam int WORD_WIDTH         = 32;
   localparam int REGISTER_FILE_SIZE = 32;
   localparam int REG_IDX_WIDTH      = $clog2(REGISTER_FILE_SIZE);
   // Per write port: {write_enable, register, data}
   localparam int REQUEST_WIDTH      = 1 + REG_IDX_WIDTH + WORD_WIDTH;
endpackage

module register_writeback
   import processor_help::*;
#(
   parameter int NUM_RESULTS = 2,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                                      clk_in,
   input  logic                                      rst_in,
   input  logic [NUM_RESULTS-1:0]                    result_valid_in,
   input  logic [NUM_RESULTS*REG_IDX_WIDTH-1:0]      result_reg_in,
   input  logic [NUM_RESULTS*WORD_WIDTH-1:0]         result_data_in,
   output logic                                      result_ready_out,
   input  logic                                      stall_in,
   output logic [SUPER_SCALAR_WIDTH*REQUEST_WIDTH-1:0] write_ports_reg_request_out,
   output logic [$clog2(FIFO_DEPTH):0]               occupancy_out,
   output logic                                      empty_out
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RW    = REG_IDX_WIDTH;
   localparam int DW    = WORD_WIDTH;
   localparam int SSW   = SUPER_SCALAR_WIDTH;

   logic [RW-1:0]    mem_reg  [FIFO_DEPTH];
   logic [DW-1:0]    mem_data [FIFO_DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] free_slots;
   logic [CNT_W-1:0] enq_count;
   logic [CNT_W-1:0] pop_count;
   logic             ready;
   logic [NUM_RESULTS-1:0] take;
   logic [PTR_W-1:0] enq_off [NUM_RESULTS];

   logic [SSW-1:0]   slot_we;
   logic [RW-1:0]    slot_reg  [SSW];
   logic [DW-1:0]    slot_data [SSW];

   // Accept only when every port could be absorbed at once. The decision uses
   // the registered occupancy, and reset holds ready low without waiting for a clock edge.
   always_comb begin
      free_slots = CNT_W'(FIFO_DEPTH) - count;
      ready      = rst_in && (free_slots >= CNT_W'(NUM_RESULTS));
   end

   assign result_ready_out = ready;

   // Pack accepted ports into consecutive tail slots, lowest port first; writes to x0 are dropped.
   always_comb begin
      logic [CNT_W-1:0] acc;
      acc  = '0;
      take = '0;
      for (int i = 0; i < NUM_RESULTS; i++) begin
         take[i]    = ready && result_valid_in[i] && (result_reg_in[i*RW +: RW] != '0);
         enq_off[i] = acc[PTR_W-1:0];
         if (take[i]) acc = acc + CNT_W'(1);
      end
      enq_count = acc;
   end

   // Select the head run to drain. Stop at the first entry that writes a register already selected this cycle.
   always_comb begin
      logic stop;
      logic clash;
      stop      = stall_in;
      clash     = 1'b0;
      pop_count = '0;
      for (int k = 0; k < SSW; k++) begin
         clash = 1'b0;
         for (int j = 0; j < k; j++) begin
            if (mem_reg[head + PTR_W'(j)] == mem_reg[head + PTR_W'(k)]) clash = 1'b1;
         end
         if (!stop && (CNT_W'(k) < count) && !clash) pop_count = CNT_W'(k + 1);
         else                                         stop      = 1'b1;
      end
   end

   // Entry storage. Validity comes from the pointers, so this array has no reset.
   always_ff @(posedge clk_in) begin
      for (int i = 0; i < NUM_RESULTS; i++) begin
         if (take[i]) begin
            mem_reg[tail + enq_off[i]]  <= result_reg_in[i*RW +: RW];
            mem_data[tail + enq_off[i]] <= result_data_in[i*DW +: DW];
         end
      end
   end

   // Head, tail and occupancy; pushes and pops in the same cycle net out.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_count[PTR_W-1:0];
         tail  <= tail + enq_count[PTR_W-1:0];
         count <= count + enq_count - pop_count;
      end
   end

   // Register the write requests. Each is presented for one cycle, and unused slots read as zero.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         slot_we <= '0;
         for (int k = 0; k < SSW; k++) begin
            slot_reg[k]  <= '0;
            slot_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < SSW; k++) begin
            if (CNT_W'(k) < pop_count) begin
               slot_we[k]   <= 1'b1;
               slot_reg[k]  <= mem_reg[head + PTR_W'(k)];
               slot_data[k] <= mem_data[head + PTR_W'(k)];
            end else begin
               slot_we[k]   <= 1'b0;
               slot_reg[k]  <= '0;
               slot_data[k] <= '0;
            end
         end
      end
   end

   // Flatten the slots onto the write-port bus.
   always_comb begin
      write_ports_reg_request_out = '0;
      for (int k = 0; k < SSW; k++) begin
         write_ports_reg_request_out[k*REQUEST_WIDTH +: REQUEST_WIDTH] =
            {slot_we[k], slot_reg[k], slot_data[k]};
      end
   end

   assign occupancy_out = count;
   assign empty_out     = (count == '0) && !(|slot_we);

endmodule

// File: tb/tb_register_writeback.sv
// Directed and random checks for register_writeback.
module tb_register_writeback;
   import processor_help::*;

   localparam int NR = 2;
   localparam int FD = 8;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [1:0]  result_valid = '0;
   logic [9:0]  result_reg   = '0;
   logic [63:0] result_data  = '0;
   logic        stall        = 1'b0;
   logic        ready;
   logic [SUPER_SCALAR_WIDTH*REQUEST_WIDTH-1:0] wp;
   logic [3:0]  occ;
   logic        empty;

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic        e_we   [2];
   logic [4:0]  e_reg  [2];
   logic [31:0] e_data [2];
   logic [1:0]  rv;
   logic [4:0]  rr0, rr1;
   logic [31:0] rd0, rd1;
   logic        rs, rdy, stop, coll;
   int          npop;
   logic [4:0]  base;
   logic [31:0] dbase;

   register_writeback #(.NUM_RESULTS(NR), .FIFO_DEPTH(FD)) dut (
      .clk_in                      (clk_in),
      .rst_in                      (rst_in),
      .result_valid_in             (result_valid),
      .result_reg_in               (result_reg),
      .result_data_in              (result_data),
      .result_ready_out            (ready),
      .stall_in                    (stall),
      .write_ports_reg_request_out (wp),
      .occupancy_out               (occ),
      .empty_out                   (empty)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic s_we(int k);
      return wp[k*REQUEST_WIDTH + REQUEST_WIDTH - 1];
   endfunction
   function automatic logic [4:0] s_reg(int k);
      return wp[k*REQUEST_WIDTH + WORD_WIDTH +: 5];
   endfunction
   function automatic logic [31:0] s_data(int k);
      return wp[k*REQUEST_WIDTH +: 32];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_slot(input string tag, input int k, input logic we,
                             input logic [4:0] r, input logic [31:0] d);
      check({tag, "_we"},   32'(s_we(k)),   32'(we));
      check({tag, "_reg"},  32'(s_reg(k)),  32'(r));
      check({tag, "_data"}, s_data(k),      d);
   endtask

   task automatic set_in(input logic [1:0] v, input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1);
      result_valid = v;
      result_reg   = {r1, r0};
      result_data  = {d1, d0};
   endtask

   task automatic tick;
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   initial begin
      // reset state
      #12;
      check("rst_ready", 32'(ready), 0);
      check("rst_occ",   32'(occ),   0);
      check("rst_empty", 32'(empty), 1);
      check_slot("rst_s0", 0, 0, 0, 0);
      check_slot("rst_s1", 1, 0, 0, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("rel_ready", 32'(ready), 1);

      // single result
      set_in(2'b01, 5, 32'hDEADBEEF, 0, 0);
      tick;
      set_in(0, 0, 0, 0, 0);
      check("single_occ1", 32'(occ), 1);
      check_slot("single_pre_s0", 0, 0, 0, 0);
      tick;
      check_slot("single_s0", 0, 1, 5, 32'hDEADBEEF);
      check_slot("single_s1", 1, 0, 0, 0);
      check("single_occ0", 32'(occ), 0);
      tick;
      check_slot("single_post_s0", 0, 0, 0, 0);
      check("single_empty", 32'(empty), 1);

      // same-cycle collision on x7
      set_in(2'b11, 7, 1, 7, 2);
      tick;
      set_in(0, 0, 0, 0, 0);
      check("coll_occ2", 32'(occ), 2);
      tick;
      check_slot("coll_e2_s0", 0, 1, 7, 1);
      check_slot("coll_e2_s1", 1, 0, 0, 0);
      check("coll_occ1", 32'(occ), 1);
      tick;
      check_slot("coll_e3_s0", 0, 1, 7, 2);
      check_slot("coll_e3_s1", 1, 0, 0, 0);
      check("coll_occ0", 32'(occ), 0);

      // x0 discard
      set_in(2'b11, 0, 32'h55, 3, 9);
      tick;
      set_in(0, 0, 0, 0, 0);
      check("x0_occ1", 32'(occ), 1);
      tick;
      check_slot("x0_s0", 0, 1, 3, 9);
      check_slot("x0_s1", 1, 0, 0, 0);
      check("x0_occ0", 32'(occ), 0);
      tick;

      // full and pointer wrap, three rounds
      for (int rnd = 0; rnd < 3; rnd++) begin
         base  = 5'(8 * rnd + 1);
         dbase = 32'hA000_0000 | (32'(rnd) << 8);
         stall = 1'b1;
         for (int p = 0; p < 4; p++) begin
            check("full_ready_open", 32'(ready), 1);
            set_in(2'b11, base + 5'(2*p), dbase + 32'(2*p), base + 5'(2*p+1), dbase + 32'(2*p+1));
            tick;
            check("full_stall_we0", 32'(s_we(0)), 0);
         end
         set_in(0, 0, 0, 0, 0);
         check("full_occ8",   32'(occ),   8);
         check("full_ready0", 32'(ready), 0);
         stall = 1'b0;
         for (int p = 0; p < 4; p++) begin
            tick;
            check_slot("wrap_s0", 0, 1, base + 5'(2*p),   dbase + 32'(2*p));
            check_slot("wrap_s1", 1, 1, base + 5'(2*p+1), dbase + 32'(2*p+1));
            check("wrap_occ", 32'(occ), 32'(8 - 2*(p+1)));
         end
         tick;
         check("wrap_empty", 32'(empty), 1);
      end

      // reset in the middle of a drain
      stall = 1'b1;
      set_in(2'b11, 10, 100, 11, 101);
      tick;
      set_in(2'b11, 12, 102, 13, 103);
      tick;
      set_in(2'b01, 14, 104, 0, 0);
      tick;
      set_in(0, 0, 0, 0, 0);
      check("mid_occ5", 32'(occ), 5);
      stall = 1'b0;
      tick;
      check_slot("mid_s0", 0, 1, 10, 100);
      check_slot("mid_s1", 1, 1, 11, 101);
      check("mid_occ3", 32'(occ), 3);
      #1;
      rst_in = 1'b0;
      #1;
      check_slot("mid_rst_s0", 0, 0, 0, 0);
      check_slot("mid_rst_s1", 1, 0, 0, 0);
      check("mid_rst_occ",   32'(occ),   0);
      check("mid_rst_ready", 32'(ready), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("mid_rel_ready", 32'(ready), 1);
      check("mid_rel_occ",   32'(occ),   0);
      for (int c = 0; c < 3; c++) begin
         tick;
         check("stale_we0", 32'(s_we(0)), 0);
         check("stale_we1", 32'(s_we(1)), 0);
         check("stale_occ", 32'(occ),     0);
      end

      // random soak against a queue model
      for (int k = 0; k < 2; k++) begin
         e_we[k] = 1'b0; e_reg[k] = '0; e_data[k] = '0;
      end
      for (int cyc = 0; cyc < 300; cyc++) begin
         check_slot("soak_s0", 0, e_we[0], e_reg[0], e_data[0]);
         check_slot("soak_s1", 1, e_we[1], e_reg[1], e_data[1]);
         check("soak_occ",   32'(occ),   32'(q.size()));
         check("soak_bound", 32'(occ <= 4'(FD)), 1);
         rdy = (q.size() <= FD - NR);
         check("soak_ready", 32'(ready), 32'(rdy));
         if (s_we(0) && s_we(1))
            check("soak_nocoll", 32'(s_reg(0) != s_reg(1)), 1);

         rv  = 2'($urandom_range(0, 3));
         rr0 = 5'($urandom_range(0, 7));
         rr1 = 5'($urandom_range(0, 7));
         rd0 = $urandom;
         rd1 = $urandom;
         rs  = ($urandom_range(0, 3) == 0);

         for (int k = 0; k < 2; k++) begin
            e_we[k] = 1'b0; e_reg[k] = '0; e_data[k] = '0;
         end
         stop = rs;
         npop = 0;
         for (int k = 0; k < 2; k++) begin
            if (!stop && k < q.size()) begin
               coll = 1'b0;
               for (int j = 0; j < k; j++)
                  if (q[j].r == q[k].r) coll = 1'b1;
               if (coll) stop = 1'b1;
               else begin
                  e_we[k]   = 1'b1;
                  e_reg[k]  = q[k].r;
                  e_data[k] = q[k].d;
                  npop++;
               end
            end else begin
               stop = 1'b1;
            end
         end
         repeat (npop) void'(q.pop_front());
         if (rdy) begin
            if (rv[0] && rr0 != 0) q.push_back('{r: rr0, d: rd0});
            if (rv[1] && rr1 != 0) q.push_back('{r: rr1, d: rd1});
         end

         stall = rs;
         set_in(rv, rr0, rd0, rr1, rd1);
         tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
